// File: rtl/ultrasound_pkg.sv
// Shared types and input-path latency for the ultrasound echo receiver.
// RX_DEGLITCH_EN selects the majority-filtered input path (SYNC_LAT 5 instead of 3).
package ultrasound_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} rx_state_t;

`ifdef RX_DEGLITCH_EN
    localparam int unsigned SYNC_LAT = 5;
`else
    localparam int unsigned SYNC_LAT = 3;
`endif

endpackage

// File: rtl/rx_edge_detect.sv
// Comparator input conditioning: 2-FF synchroniser, optional 3-sample majority
// filter (RX_DEGLITCH_EN), then a registered rising-edge strobe.
module rx_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic rx_in,
    output logic edge_stb
);

    logic sync1, sync2;
    logic level, level_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

`ifdef RX_DEGLITCH_EN
    logic hist1, hist2, filt;

    // A single odd sample is outvoted by its two neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            filt  <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            filt  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_d  <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            level_d  <= level;
            edge_stb <= level & ~level_d;
        end
    end

endmodule

// File: rtl/ultrasound_echo_receiver.sv
// Echo receiver: blanks ring-down after tx_start, qualifies carrier periods and
// reports time of flight. Build option RX_DEGLITCH_EN adds an input majority filter.
module ultrasound_echo_receiver
    import ultrasound_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 9,
    parameter int unsigned PERIOD_TOL  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        tx_start,
    input  logic        rx_in,
    input  logic [31:0] blank_len,
    input  logic [31:0] timeout,
    input  logic [15:0] min_cycles,
    output logic [31:0] tof,
    output logic        tof_valid,
    output logic        rx_timeout,
    output logic        busy,
    output rx_state_t   dbg_state
);

    localparam logic [31:0] IVL_LO = (2 * HALF_PERIOD > PERIOD_TOL) ?
                                     32'(2 * HALF_PERIOD - PERIOD_TOL) : 32'd0;
    localparam logic [31:0] IVL_HI = 32'(2 * HALF_PERIOD + PERIOD_TOL);

    rx_state_t   state;
    logic [31:0] tof_cnt;
    logic [15:0] ivl_cnt;
    logic [31:0] run_start;
    logic [15:0] run_len;
    logic        have_edge;
    logic        edge_stb;

    logic        restart;
    logic        ivl_ok;
    logic [15:0] target;
    logic [15:0] run_len_inc;
    logic        det;
    logic [31:0] tof_corr;

    rx_edge_detect u_edge (
        .clk      (clk),
        .rstn     (rstn),
        .rx_in    (rx_in),
        .edge_stb (edge_stb)
    );

    assign restart     = tx_start & enable;
    assign ivl_ok      = ({16'd0, ivl_cnt} >= IVL_LO) && ({16'd0, ivl_cnt} <= IVL_HI);
    assign target      = (min_cycles == 16'd0) ? 16'd1 : min_cycles;
    assign run_len_inc = (run_len == 16'hFFFF) ? run_len : run_len + 16'd1;
    assign det         = (state == LISTEN) && edge_stb && have_edge && ivl_ok &&
                         (run_len_inc >= target);
    // Edge strobes lag rx_in by SYNC_LAT, so the run start is pulled back by that much.
    assign tof_corr    = (run_start >= 32'(SYNC_LAT)) ? run_start - 32'(SYNC_LAT) : 32'd0;

    assign busy      = (state == BLANK) || (state == LISTEN);
    assign dbg_state = state;

    // tof_valid and rx_timeout are single-cycle strobes with no back-pressure;
    // tof is stable while tof_valid is high and holds until the next detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            tof_cnt    <= 32'd0;
            ivl_cnt    <= 16'd0;
            run_start  <= 32'd0;
            run_len    <= 16'd0;
            have_edge  <= 1'b0;
            tof        <= 32'd0;
            tof_valid  <= 1'b0;
            rx_timeout <= 1'b0;
        end else begin
            tof_valid  <= 1'b0;
            rx_timeout <= 1'b0;
            tof_cnt    <= (tof_cnt == 32'hFFFF_FFFF) ? tof_cnt : tof_cnt + 32'd1;
            if (edge_stb)
                ivl_cnt <= 16'd1;
            else if (ivl_cnt != 16'hFFFF)
                ivl_cnt <= ivl_cnt + 16'd1;

            if (!enable) begin
                state <= IDLE;
            end else if (restart) begin
                state     <= BLANK;
                tof_cnt   <= 32'd0;
                run_start <= 32'd0;
                run_len   <= 16'd0;
                have_edge <= 1'b0;
            end else begin
                case (state)
                    BLANK: begin
                        if (tof_cnt >= blank_len)
                            state <= LISTEN;
                    end
                    LISTEN: begin
                        if (edge_stb) begin
                            if (!have_edge || !ivl_ok) begin
                                have_edge <= 1'b1;
                                run_start <= tof_cnt;
                                run_len   <= 16'd0;
                            end else if (det) begin
                                tof       <= tof_corr;
                                tof_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                run_len <= run_len_inc;
                            end
                        end
                        if (!det && (tof_cnt >= timeout)) begin
                            rx_timeout <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
